// File: rtl/circ_fifo_pkg.sv
// Shared width helpers for the circular-buffer FIFO.
package circ_fifo_pkg;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned clog2_cnt(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width: index bits plus one wrap bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/circ_fifo_ptr.sv
// Wrapping FIFO pointer: index bits plus an MSB wrap bit, with increment
// enable and synchronous clear.
module circ_fifo_ptr import circ_fifo_pkg::*; #(
    parameter int unsigned PtrW = ptr_w(8)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [PtrW-1:0] ptr_o
);

    logic [PtrW-1:0] ptr_q, ptr_d;

    // Next pointer: clear wins, otherwise step; the power-of-2 depth makes the
    // index wrap naturally while the MSB toggles.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PtrW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/circ_fifo.sv
// Parametrised circular-buffer FIFO with show-ahead output, occupancy
// status and sticky overflow/underflow flags.
// Optional: define CIRC_FIFO_CLR_EN to add the synchronous flush input clr.
module circ_fifo import circ_fifo_pkg::*; #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned BITS      = 64,
    parameter int unsigned AF_THRESH = DEPTH - 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
`ifdef CIRC_FIFO_CLR_EN
    input  logic                        clr,
`endif
    input  logic                        push,
    input  logic [BITS-1:0]             d,
    input  logic                        pop,
    output logic [BITS-1:0]             q,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic [clog2_cnt(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int unsigned PtrW  = ptr_w(DEPTH);
    localparam int unsigned AddrW = PtrW - 1;
    localparam int unsigned CntW  = clog2_cnt(DEPTH);
    localparam logic [CntW-1:0] AfThresh = CntW'(AF_THRESH);

    logic [BITS-1:0]  mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic [AddrW-1:0] wr_addr, rd_addr;
    logic [CntW-1:0]  count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             clr_w;
    logic             push_acc, pop_acc;

`ifdef CIRC_FIFO_CLR_EN
    assign clr_w = clr;
`else
    assign clr_w = 1'b0;
`endif

    assign wr_addr = wr_ptr[AddrW-1:0];
    assign rd_addr = rd_ptr[AddrW-1:0];

    // Status from registered pointers/count only, never from push/pop.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PtrW-1] != rd_ptr[PtrW-1]) && (wr_addr == rd_addr);
    assign almost_full = (count_q >= AfThresh);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign q           = empty ? '0 : mem_q[rd_addr];

    // Accept decisions on pre-edge state; a push into a full FIFO is fine when
    // the head leaves in the same cycle. A flush suppresses both.
    always_comb begin
        push_acc = push & (~full | pop) & ~clr_w;
        pop_acc  = pop & ~empty & ~clr_w;
    end

    // Occupancy and sticky error flags.
    always_comb begin
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clr_w) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push_acc && !pop_acc) begin
                count_d = count_q + CntW'(1);
            end else if (!push_acc && pop_acc) begin
                count_d = count_q - CntW'(1);
            end
            if (push && !push_acc) begin
                overflow_d = 1'b1;
            end
            if (pop && !pop_acc) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage: reset zeroes every entry; a flush leaves contents in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_acc) begin
            mem_q[wr_addr] <= d;
        end
    end

    circ_fifo_ptr #(
        .PtrW (PtrW)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_w),
        .inc_i (push_acc),
        .ptr_o (wr_ptr)
    );

    circ_fifo_ptr #(
        .PtrW (PtrW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr_w),
        .inc_i (pop_acc),
        .ptr_o (rd_ptr)
    );

endmodule
